// File: rtl/bram2be_pkg.sv
// Shared write-mode constants and the lane-merge helper used by both RAM ports.
// Pure definitions: no latency or backpressure of its own.
package bram2be_pkg;

  localparam int BRAM_WRITE_FIRST = 0;
  localparam int BRAM_READ_FIRST  = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int BRAM_MAX_DW = 512;
  localparam int BRAM_IDX_W  = $clog2(BRAM_MAX_DW);

  typedef logic [BRAM_MAX_DW-1:0] bram_word_t;

  // Enables arrive one bit per lane; bit i of the word follows enable i/chunk.
  function automatic bram_word_t bram_merge(input bram_word_t old_w,
                                            input bram_word_t new_w,
                                            input bram_word_t we,
                                            input int         chunk);
    bram_word_t res;
    res = old_w;
    for (int i = 0; i < BRAM_MAX_DW; i++) begin
      if (we[BRAM_IDX_W'(i / chunk)]) res[BRAM_IDX_W'(i)] = new_w[BRAM_IDX_W'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram2be_rsp_fifo.sv
// Generic circular response FIFO with async active-low reset; head is zero when empty.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: none upstream; pushes into a full FIFO are dropped, callers bound occupancy.
module bram2be_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_dat_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push    = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop     = pop_i && (cnt_q != '0);
  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = empty_o ? '0 : buf_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) buf_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/bram2be_srv.sv
// Dual-port lane-enable BRAM with valid/ready requests and credit-buffered responses; BRAM2BE_COLLISION_EN adds a sticky COLLISION flag.
// Latency: a request accepted at edge N shows its response the cycle after edge N+1+PIPELINED.
// Backpressure: REQ_READY_x drops with RSP_DEPTH responses outstanding; no combinational path from RSP_READY_x.
module bram2be_srv
  import bram2be_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int CHUNKSIZE  = 8,
  parameter int WE_WIDTH   = 4,
  parameter int MEMSIZE    = 1024,
  parameter int PIPELINED  = 0,
  parameter int WRITE_MODE = 0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            REQ_VALID_A,
  output logic                            REQ_READY_A,
  input  logic [WE_WIDTH-1:0]             REQ_WE_A,
  input  logic [ADDR_WIDTH-1:0]           REQ_ADDR_A,
  input  logic [CHUNKSIZE*WE_WIDTH-1:0]   REQ_DATA_A,
  output logic                            RSP_VALID_A,
  input  logic                            RSP_READY_A,
  output logic [CHUNKSIZE*WE_WIDTH-1:0]   RSP_DATA_A,
  input  logic                            REQ_VALID_B,
  output logic                            REQ_READY_B,
  input  logic [WE_WIDTH-1:0]             REQ_WE_B,
  input  logic [ADDR_WIDTH-1:0]           REQ_ADDR_B,
  input  logic [CHUNKSIZE*WE_WIDTH-1:0]   REQ_DATA_B,
  output logic                            RSP_VALID_B,
  input  logic                            RSP_READY_B,
  output logic [CHUNKSIZE*WE_WIDTH-1:0]   RSP_DATA_B
`ifdef BRAM2BE_COLLISION_EN
  , output logic                          COLLISION
`endif
);

  localparam int DW = CHUNKSIZE * WE_WIDTH;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [DW-1:0] mem [MEMSIZE];

  logic          run_q;
  logic [CW-1:0] cred_a_q, cred_a_d, cred_b_q, cred_b_d;
  logic          acc_a, acc_b, pop_a, pop_b, wr_a, wr_b, same_addr;
  logic [DW-1:0] old_a, old_b, mrg_a, mrg_b, mrg_ab, rsp_a_d, rsp_b_d;
  logic          s1_vld_a_q, s1_vld_b_q, push_a, push_b, empty_a, empty_b;
  logic [DW-1:0] s1_dat_a_q, s1_dat_b_q, push_dat_a, push_dat_b;

  // run_q keeps both ports closed while reset is held and opens them one edge later.
  assign REQ_READY_A = run_q && (cred_a_q != '0);
  assign REQ_READY_B = run_q && (cred_b_q != '0);
  assign acc_a       = REQ_VALID_A && REQ_READY_A;
  assign acc_b       = REQ_VALID_B && REQ_READY_B;
  assign pop_a       = RSP_VALID_A && RSP_READY_A;
  assign pop_b       = RSP_VALID_B && RSP_READY_B;
  assign wr_a        = |REQ_WE_A;
  assign wr_b        = |REQ_WE_B;
  assign same_addr   = (REQ_ADDR_A == REQ_ADDR_B);

  assign old_a  = mem[REQ_ADDR_A];
  assign old_b  = mem[REQ_ADDR_B];
  assign mrg_a  = DW'(bram_merge(bram_word_t'(old_a), bram_word_t'(REQ_DATA_A), bram_word_t'(REQ_WE_A), CHUNKSIZE));
  assign mrg_b  = DW'(bram_merge(bram_word_t'(old_b), bram_word_t'(REQ_DATA_B), bram_word_t'(REQ_WE_B), CHUNKSIZE));
  // Same-address double write: A's lanes land on top of B's merge.
  assign mrg_ab = DW'(bram_merge(bram_word_t'(mrg_b), bram_word_t'(REQ_DATA_A), bram_word_t'(REQ_WE_A), CHUNKSIZE));

  assign rsp_a_d = (WRITE_MODE == BRAM_READ_FIRST || !wr_a) ? old_a : mrg_a;
  assign rsp_b_d = (WRITE_MODE == BRAM_READ_FIRST || !wr_b) ? old_b : mrg_b;

  always_comb begin
    cred_a_d = cred_a_q;
    cred_b_d = cred_b_q;
    if (acc_a && !pop_a) cred_a_d = cred_a_q - CW'(1);
    if (pop_a && !acc_a) cred_a_d = cred_a_q + CW'(1);
    if (acc_b && !pop_b) cred_b_d = cred_b_q - CW'(1);
    if (pop_b && !acc_b) cred_b_d = cred_b_q + CW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q      <= 1'b0;
      cred_a_q   <= CW'(RSP_DEPTH);
      cred_b_q   <= CW'(RSP_DEPTH);
      s1_vld_a_q <= 1'b0;
      s1_vld_b_q <= 1'b0;
      s1_dat_a_q <= '0;
      s1_dat_b_q <= '0;
    end else begin
      run_q      <= 1'b1;
      cred_a_q   <= cred_a_d;
      cred_b_q   <= cred_b_d;
      s1_vld_a_q <= acc_a;
      s1_vld_b_q <= acc_b;
      s1_dat_a_q <= rsp_a_d;
      s1_dat_b_q <= rsp_b_d;
    end
  end

  // Array is not reset so committed writes survive a mid-operation reset.
  always_ff @(posedge CLK) begin
    if (acc_b && wr_b) mem[REQ_ADDR_B] <= mrg_b;
    if (acc_a && wr_a) mem[REQ_ADDR_A] <= (acc_b && wr_b && same_addr) ? mrg_ab : mrg_a;
  end

  if (PIPELINED != 0) begin : g_pipe
    logic          s2_vld_a_q, s2_vld_b_q;
    logic [DW-1:0] s2_dat_a_q, s2_dat_b_q;
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s2_vld_a_q <= 1'b0;
        s2_vld_b_q <= 1'b0;
        s2_dat_a_q <= '0;
        s2_dat_b_q <= '0;
      end else begin
        s2_vld_a_q <= s1_vld_a_q;
        s2_vld_b_q <= s1_vld_b_q;
        s2_dat_a_q <= s1_dat_a_q;
        s2_dat_b_q <= s1_dat_b_q;
      end
    end
    assign push_a     = s2_vld_a_q;
    assign push_b     = s2_vld_b_q;
    assign push_dat_a = s2_dat_a_q;
    assign push_dat_b = s2_dat_b_q;
  end else begin : g_nopipe
    assign push_a     = s1_vld_a_q;
    assign push_b     = s1_vld_b_q;
    assign push_dat_a = s1_dat_a_q;
    assign push_dat_b = s1_dat_b_q;
  end

  bram2be_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DW)) u_rsp_fifo_a (
    .clk_i(CLK), .rst_ni(RST_N), .push_i(push_a), .push_dat_i(push_dat_a),
    .pop_i(pop_a), .empty_o(empty_a), .head_dat_o(RSP_DATA_A)
  );

  bram2be_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DW)) u_rsp_fifo_b (
    .clk_i(CLK), .rst_ni(RST_N), .push_i(push_b), .push_dat_i(push_dat_b),
    .pop_i(pop_b), .empty_o(empty_b), .head_dat_o(RSP_DATA_B)
  );

  assign RSP_VALID_A = !empty_a;
  assign RSP_VALID_B = !empty_b;

`ifdef BRAM2BE_COLLISION_EN
  logic coll_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) coll_q <= 1'b0;
    else if (acc_a && acc_b && same_addr && (wr_a || wr_b)) coll_q <= 1'b1;
  end
  assign COLLISION = coll_q;
`endif

endmodule
